// File: rtl/iurt_wb_master_if.sv
// Signal bundle between the byte-stream hub side, the Wishbone slave side and iurt_wb_master.
interface iurt_wb_master_if;
    logic        data_dwn_ready;
    logic        data_dwn_valid;
    logic [7:0]  data_dwn;
    logic        data_up_ready;
    logic        data_up_valid;
    logic [7:0]  data_up;
    logic        cyc_o;
    logic        stb_o;
    logic        we_o;
    logic [31:0] adr_o;
    logic [3:0]  sel_o;
    logic [31:0] dat_o;
    logic [31:0] dat_i;
    logic        ack_i;
    logic        err_i;

    modport master (
        output data_dwn_ready, input data_dwn_valid, input data_dwn,
        input data_up_ready, output data_up_valid, output data_up,
        output cyc_o, output stb_o, output we_o, output adr_o, output sel_o, output dat_o,
        input dat_i, input ack_i, input err_i
    );

    modport slave (
        input data_dwn_ready, output data_dwn_valid, output data_dwn,
        output data_up_ready, input data_up_valid, input data_up,
        input cyc_o, input stb_o, input we_o, input adr_o, input sel_o, input dat_o,
        output dat_i, output ack_i, output err_i
    );
endinterface

// File: rtl/iurt_wb_master.sv
// Byte-stream to Wishbone classic initiator: decodes command frames from the hub,
// runs one bus cycle per frame and returns a status byte plus read data.
module iurt_wb_master #(
    parameter int ASYNC_RESET = 1,
    parameter int TIMEOUT     = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    iurt_wb_master_if.master bus
);
    localparam int CW = $clog2(TIMEOUT + 2);
    localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_DATA = 3'd2,
        ST_BUS  = 3'd3,
        ST_STAT = 3'd4,
        ST_RDAT = 3'd5
    } state_t;

    typedef struct packed {
        state_t        state;
        logic [1:0]    bcnt;
        logic [CW-1:0] tcnt;
        logic          we;
        logic [3:0]    sel;
        logic [31:0]   adr;
        logic [31:0]   dat;
        logic [31:0]   rdat;
        logic [1:0]    status;
        logic          cyc;
        logic          up_valid;
        logic [7:0]    up_data;
        logic          dwn_ready;
    } regs_t;

    localparam regs_t RST_VAL = '{
        state: ST_IDLE, bcnt: 2'd0, tcnt: '0, we: 1'b0, sel: 4'd0,
        adr: 32'd0, dat: 32'd0, rdat: 32'd0, status: 2'd0, cyc: 1'b0,
        up_valid: 1'b0, up_data: 8'd0, dwn_ready: 1'b1
    };

    regs_t regs_q;
    regs_t regs_d;
    logic  take_s;
    logic  cmd_ok_s;

    // Next-state logic; only applied on ce cycles, so up_valid defaults low to form a one-ce pulse.
    always_comb begin
        regs_d          = regs_q;
        regs_d.up_valid = 1'b0;
        take_s          = bus.data_dwn_valid & regs_q.dwn_ready;
        cmd_ok_s        = (bus.data_dwn[7:6] == 2'b01) || (bus.data_dwn[7:6] == 2'b10);
        case (regs_q.state)
            ST_IDLE: begin
                if (take_s && cmd_ok_s) begin
                    regs_d.we    = (bus.data_dwn[7:6] == 2'b01);
                    regs_d.sel   = bus.data_dwn[3:0];
                    regs_d.bcnt  = 2'd0;
                    regs_d.state = ST_ADDR;
                end else begin
                    regs_d.state = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (take_s) begin
                    regs_d.adr[{regs_q.bcnt, 3'b000} +: 8] = bus.data_dwn;
                    regs_d.bcnt = regs_q.bcnt + 2'd1;
                    if (regs_q.bcnt == 2'd3) begin
                        regs_d.state = regs_q.we ? ST_DATA : ST_BUS;
                    end else begin
                        regs_d.state = ST_ADDR;
                    end
                end else begin
                    regs_d.state = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (take_s) begin
                    regs_d.dat[{regs_q.bcnt, 3'b000} +: 8] = bus.data_dwn;
                    regs_d.bcnt = regs_q.bcnt + 2'd1;
                    regs_d.state = (regs_q.bcnt == 2'd3) ? ST_BUS : ST_DATA;
                end else begin
                    regs_d.state = ST_DATA;
                end
            end
            ST_BUS: begin
                // err_i takes priority over a simultaneous ack_i.
                if (bus.err_i) begin
                    regs_d.status = 2'd1;
                    regs_d.state  = ST_STAT;
                end else if (bus.ack_i) begin
                    regs_d.status = 2'd0;
                    regs_d.rdat   = bus.dat_i;
                    regs_d.state  = ST_STAT;
                end else if ((TIMEOUT != 0) && (regs_q.tcnt >= TO_LAST)) begin
                    regs_d.status = 2'd2;
                    regs_d.state  = ST_STAT;
                end else begin
                    regs_d.tcnt = (regs_q.tcnt == {CW{1'b1}}) ? regs_q.tcnt : regs_q.tcnt + CW'(1);
                end
            end
            ST_STAT: begin
                if (bus.data_up_ready) begin
                    regs_d.up_valid = 1'b1;
                    regs_d.up_data  = {6'd0, regs_q.status};
                    regs_d.bcnt     = 2'd0;
                    regs_d.state    = ((regs_q.status == 2'd0) && !regs_q.we) ? ST_RDAT : ST_IDLE;
                end else begin
                    regs_d.state = ST_STAT;
                end
            end
            ST_RDAT: begin
                if (bus.data_up_ready) begin
                    regs_d.up_valid = 1'b1;
                    regs_d.up_data  = regs_q.rdat[{regs_q.bcnt, 3'b000} +: 8];
                    regs_d.bcnt     = regs_q.bcnt + 2'd1;
                    regs_d.state    = (regs_q.bcnt == 2'd3) ? ST_IDLE : ST_RDAT;
                end else begin
                    regs_d.state = ST_RDAT;
                end
            end
            default: begin
                regs_d.state = ST_IDLE;
            end
        endcase
        regs_d.cyc       = (regs_d.state == ST_BUS);
        regs_d.tcnt      = (regs_q.state == ST_BUS) ? regs_d.tcnt : '0;
        regs_d.dwn_ready = (regs_d.state == ST_IDLE) || (regs_d.state == ST_ADDR) ||
                           (regs_d.state == ST_DATA);
    end

    generate
        if (ASYNC_RESET != 0) begin : g_async_rst
            // State register with asynchronous reset so cyc_o drops as soon as rst rises.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    regs_q <= RST_VAL;
                end else if (ce) begin
                    regs_q <= regs_d;
                end
            end
        end else begin : g_sync_rst
            // State register with synchronous reset for targets without async flops.
            always_ff @(posedge clk) begin
                if (rst) begin
                    regs_q <= RST_VAL;
                end else if (ce) begin
                    regs_q <= regs_d;
                end
            end
        end
    endgenerate

    assign bus.data_dwn_ready = regs_q.dwn_ready;
    assign bus.data_up_valid  = regs_q.up_valid;
    assign bus.data_up        = regs_q.up_data;
    assign bus.cyc_o          = regs_q.cyc;
    assign bus.stb_o          = regs_q.cyc;
    assign bus.we_o           = regs_q.we;
    assign bus.adr_o          = regs_q.adr;
    assign bus.sel_o          = regs_q.sel;
    assign bus.dat_o          = regs_q.dat;
endmodule

// File: tb/tb_iurt_wb_master.sv
// Self-checking bench for iurt_wb_master: directed and random frames against a transaction-level model.
module tb_iurt_wb_master;
    logic clk = 1'b0;
    logic rst;
    logic ce;

    iurt_wb_master_if bus ();
    iurt_wb_master_if bus0 ();

    iurt_wb_master #(.ASYNC_RESET(1), .TIMEOUT(8)) dut (.clk(clk), .rst(rst), .ce(ce), .bus(bus));
    iurt_wb_master #(.ASYNC_RESET(1), .TIMEOUT(0)) dut0 (.clk(clk), .rst(rst), .ce(ce), .bus(bus0));

    assign bus0.data_dwn_valid = bus.data_dwn_valid;
    assign bus0.data_dwn       = bus.data_dwn;
    assign bus0.data_up_ready  = bus.data_up_ready;
    assign bus0.dat_i          = bus.dat_i;
    assign bus0.ack_i          = bus.ack_i;
    assign bus0.err_i          = bus.err_i;

    always #5 clk = ~clk;

    int         nchk = 0;
    int         nfail = 0;
    bit         ce_rand = 1'b0;
    bit         rdy_rand = 1'b0;
    bit         prev_rdy = 1'b0;
    logic [7:0] up_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        ce = 1'b1;
        forever begin
            @(posedge clk); #1;
            ce = ce_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        bus.data_up_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            bus.data_up_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Up-stream monitor: one byte per ce cycle with valid; launch edge must have seen ready.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_rdy = 1'b0;
            end else if (ce) begin
                if (bus.data_up_valid) begin
                    chk("up_valid_needs_ready", {63'd0, prev_rdy}, 64'd1);
                    up_q.push_back(bus.data_up);
                end
                prev_rdy = bus.data_up_ready;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bit ok = 1'b0;
        @(posedge clk); #1;
        bus.data_dwn_valid = 1'b1;
        bus.data_dwn       = b;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ce && bus.data_dwn_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("dwn_accept_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        bus.data_dwn_valid = 1'b0;
    endtask

    task automatic send_frame(input bit is_wr, input logic [1:0] mid, input logic [3:0] sel,
                              input logic [31:0] adr, input logic [31:0] wdat);
        send_byte({(is_wr ? 2'b01 : 2'b10), mid, sel});
        for (int k = 0; k < 4; k++) send_byte(8'((adr >> (8 * k)) & 32'hFF));
        if (is_wr) for (int k = 0; k < 4; k++) send_byte(8'((wdat >> (8 * k)) & 32'hFF));
    endtask

    task automatic wait_cyc();
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.cyc_o) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("cyc_start_timeout", 64'd0, 64'd1);
    endtask

    // kind: 0 ack, 1 err, 2 err+ack together, 3 slave silent
    task automatic run_txn(input bit is_wr, input logic [1:0] mid, input logic [3:0] sel,
                           input logic [31:0] adr, input logic [31:0] wdat,
                           input logic [31:0] rdat, input int delay, input int kind);
        logic [7:0] exp_q[$];
        logic [7:0] status;
        int         n = 0;
        bit         hold_ok = 1'b1;
        up_q.delete();
        send_frame(is_wr, mid, sel, adr, wdat);
        wait_cyc();
        chk("adr_o", {32'd0, bus.adr_o}, {32'd0, adr});
        chk("sel_o", {60'd0, bus.sel_o}, {60'd0, sel});
        chk("we_o", {63'd0, bus.we_o}, {63'd0, is_wr});
        chk("stb_o", {63'd0, bus.stb_o}, 64'd1);
        chk("dwn_ready_in_bus", {63'd0, bus.data_dwn_ready}, 64'd0);
        if (is_wr) chk("dat_o", {32'd0, bus.dat_o}, {32'd0, wdat});
        for (int i = 0; i < 400; i++) begin
            if (!bus.cyc_o) break;
            if (bus.adr_o !== adr || bus.sel_o !== sel || bus.stb_o !== 1'b1) hold_ok = 1'b0;
            if (ce) begin
                n++;
                if (kind != 3 && n == delay) begin
                    bus.ack_i = (kind != 1);
                    bus.err_i = (kind != 0);
                    bus.dat_i = rdat;
                    @(posedge clk); #1;
                    bus.ack_i = 1'b0;
                    bus.err_i = 1'b0;
                    bus.dat_i = $urandom;
                end
            end
            @(negedge clk);
        end
        chk("bus_fields_hold", {63'd0, hold_ok}, 64'd1);
        chk("cyc_ce_cycles", 64'(n), 64'((kind == 3) ? 8 : delay));
        status = (kind == 3) ? 8'h02 : ((kind == 0) ? 8'h00 : 8'h01);
        exp_q.push_back(status);
        if (status == 8'h00 && !is_wr)
            for (int k = 0; k < 4; k++) exp_q.push_back(8'((rdat >> (8 * k)) & 32'hFF));
        for (int i = 0; i < 2000; i++) begin
            if (up_q.size() >= exp_q.size()) break;
            @(negedge clk);
        end
        repeat (20) @(negedge clk);
        chk("up_byte_count", 64'(up_q.size()), 64'(exp_q.size()));
        for (int k = 0; k < exp_q.size(); k++)
            chk($sformatf("up_byte%0d", k), {56'd0, up_q[k]}, {56'd0, exp_q[k]});
        chk("dwn_ready_after", {63'd0, bus.data_dwn_ready}, 64'd1);
    endtask

    initial begin
        int  cnt;
        bit  saw_cyc;
        rst = 1'b1;
        bus.data_dwn_valid = 1'b0;
        bus.data_dwn       = 8'h00;
        bus.dat_i          = 32'h0;
        bus.ack_i          = 1'b0;
        bus.err_i          = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_dwn_ready", {63'd0, bus.data_dwn_ready}, 64'd1);
        chk("rst_up_valid", {63'd0, bus.data_up_valid}, 64'd0);
        chk("rst_cyc", {63'd0, bus.cyc_o}, 64'd0);
        chk("rst_stb", {63'd0, bus.stb_o}, 64'd0);
        chk("rst_we", {63'd0, bus.we_o}, 64'd0);
        chk("rst_sel", {60'd0, bus.sel_o}, 64'd0);
        chk("rst_adr", {32'd0, bus.adr_o}, 64'd0);
        chk("rst_dat", {32'd0, bus.dat_o}, 64'd0);
        chk("rst_up_data", {56'd0, bus.data_up}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed write, read with random up-ready, err+ack together.
        run_txn(1'b1, 2'b00, 4'hF, 32'h8000_0010, 32'hDEAD_BEEF, 32'h0, 3, 0);
        rdy_rand = 1'b1;
        run_txn(1'b0, 2'b00, 4'hF, 32'h0000_0004, 32'h0, 32'h1234_5678, 2, 0);
        run_txn(1'b0, 2'b00, 4'h3, 32'h0000_0100, 32'h0, 32'hCAFE_F00D, 1, 2);

        // Same write with ce toggling.
        ce_rand = 1'b1;
        run_txn(1'b1, 2'b00, 4'hF, 32'h8000_0010, 32'hDEAD_BEEF, 32'h0, 3, 0);

        // Ignored opcodes produce neither bus cycle nor up byte.
        up_q.delete();
        send_byte(8'h00);
        send_byte(8'hC7);
        send_byte(8'h35);
        saw_cyc = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.cyc_o) saw_cyc = 1'b1;
        end
        chk("ignored_no_cyc", {63'd0, saw_cyc}, 64'd0);
        chk("ignored_no_up", 64'(up_q.size()), 64'd0);
        chk("ignored_dwn_ready", {63'd0, bus.data_dwn_ready}, 64'd1);

        // Random frames against the transaction model.
        for (int t = 0; t < 10; t++) begin
            run_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                    $urandom, $urandom, $urandom, $urandom_range(1, 5), $urandom_range(0, 2));
        end

        // Timeout: TIMEOUT=8 instance aborts, TIMEOUT=0 instance keeps waiting.
        ce_rand = 1'b0;
        run_txn(1'b0, 2'b00, 4'hF, 32'h0000_0040, 32'h0, 32'h0, 1, 3);
        cnt = 0;
        repeat (1000) begin
            @(negedge clk);
            if (bus0.cyc_o) cnt++;
        end
        chk("no_timeout_cyc_held", 64'(cnt), 64'd1000);

        // Reset during a bus cycle, then reset mid-frame; following frame must run normally.
        send_frame(1'b1, 2'b00, 4'hF, 32'h0000_0020, 32'h1111_2222);
        wait_cyc();
        #2 rst = 1'b1;
        #1;
        chk("rst_async_cyc", {63'd0, bus.cyc_o}, 64'd0);
        chk("rst_async_stb", {63'd0, bus.stb_o}, 64'd0);
        chk("rst_async_cyc_t0", {63'd0, bus0.cyc_o}, 64'd0);
        chk("rst_async_dwn_ready", {63'd0, bus.data_dwn_ready}, 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        send_byte(8'h4F);
        send_byte(8'h99);
        @(negedge clk); #2 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        run_txn(1'b1, 2'b00, 4'h5, 32'h0000_0030, 32'hA5A5_5A5A, 32'h0, 2, 0);
        run_txn(1'b0, 2'b00, 4'hF, 32'h0000_0034, 32'h0, 32'h0BAD_C0DE, 4, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
